// File: rtl/shadow_ram_arbiter.sv
// Arbitrates the shadow-ROM block RAM port between buffered Z80 writes and
// the SPI host. Z80 writes normally win; a starvation counter forces an SPI
// slot after STARVE_LIMIT consecutive Z80 grants. All RAM controls are registered.
module shadow_ram_arbiter #(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              z80_wr_stb,
  input  logic [ADDR_W-1:0] z80_wr_addr,
  input  logic [DATA_W-1:0] z80_wr_data,
  output logic              z80_fifo_full,
  output logic              overflow,
  input  logic              spi_req,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic              spi_ack,
  output logic [DATA_W-1:0] spi_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] fifo_addr_q [2];
  logic [DATA_W-1:0] fifo_data_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;
  logic [3:0]        starve_q, starve_d;
  logic              overflow_q;
  logic              spi_ack_q;
  logic [DATA_W-1:0] spi_rdata_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_din_q;
  logic              ram_we_q;

  logic spi_elig, pop, spi_grant, push;

  // Grant decision, FIFO accept/drop and starvation counter next state
  always_comb begin
    spi_elig  = spi_req && !spi_ack_q;
    pop       = (state_q == IDLE) && (count_q != 2'd0) &&
                (!spi_elig || (starve_q < LIMIT));
    spi_grant = (state_q == IDLE) && spi_elig && !pop;
    // a pop in the same cycle frees the slot the push needs
    push      = z80_wr_stb && ((count_q != 2'd2) || pop);
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    starve_d = starve_q;
    if (!spi_req || spi_grant)
      starve_d = '0;
    else if (pop && spi_elig && (starve_q != '1))
      starve_d = starve_q + 4'd1;
  end

  // FIFO storage; full-with-pop writes the slot whose old contents are being popped
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= z80_wr_addr;
      fifo_data_q[wr_ptr_q] <= z80_wr_data;
    end
  end

  // Arbiter FSM with registered RAM controls and SPI handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      starve_q    <= '0;
      overflow_q  <= 1'b0;
      spi_ack_q   <= 1'b0;
      spi_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_we_q    <= 1'b0;
    end else begin
      ram_we_q  <= 1'b0;
      spi_ack_q <= 1'b0;
      count_q   <= count_d;
      starve_q  <= starve_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      if (z80_wr_stb && !push) overflow_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pop) begin
            ram_addr_q <= fifo_addr_q[rd_ptr_q];
            ram_din_q  <= fifo_data_q[rd_ptr_q];
            ram_we_q   <= 1'b1;
          end else if (spi_grant) begin
            ram_addr_q <= spi_addr;
            if (spi_we) begin
              ram_din_q <= spi_wdata;
              ram_we_q  <= 1'b1;
              spi_ack_q <= 1'b1;
            end else begin
              state_q <= RD_ADDR;
            end
          end
        end
        RD_ADDR: state_q <= RD_DATA;
        RD_DATA: begin
          spi_rdata_q <= ram_dout;
          spi_ack_q   <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign z80_fifo_full = (count_q == 2'd2);
  assign overflow      = overflow_q;
  assign spi_ack       = spi_ack_q;
  assign spi_rdata     = spi_rdata_q;
  assign ram_addr      = ram_addr_q;
  assign ram_din       = ram_din_q;
  assign ram_we        = ram_we_q;
  assign busy          = (state_q != IDLE) || (count_q != 2'd0);

endmodule

// File: tb/tb_shadow_ram_arbiter.sv
// Directed bench for shadow_ram_arbiter with a registered-read block RAM stub.
module tb_shadow_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        z80_wr_stb = 1'b0;
  logic [13:0] z80_wr_addr = '0;
  logic [7:0]  z80_wr_data = '0;
  logic        z80_fifo_full, overflow;
  logic        spi_req = 1'b0, spi_we = 1'b0;
  logic [13:0] spi_addr = '0;
  logic [7:0]  spi_wdata = '0;
  logic        spi_ack;
  logic [7:0]  spi_rdata;
  logic [13:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout = '0;
  logic        busy;

  shadow_ram_arbiter #(.ADDR_W(14), .DATA_W(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .z80_wr_stb(z80_wr_stb), .z80_wr_addr(z80_wr_addr), .z80_wr_data(z80_wr_data),
    .z80_fifo_full(z80_fifo_full), .overflow(overflow),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_ack(spi_ack), .spi_rdata(spi_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // block RAM stub: synchronous write, one-cycle read latency
  logic [7:0] mem [16384];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        log_en = 1'b0;
  logic [22:0] wlog [$];
  int          wcyc [$];
  always @(negedge clk) begin
    if (log_en && ram_we) begin
      wlog.push_back({spi_ack, ram_addr, ram_din});
      wcyc.push_back(cyc);
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [13:0] a, input logic [7:0] d);
    chk({tag, "_we"},   32'(ram_we),   32'd1);
    chk({tag, "_addr"}, 32'(ram_addr), 32'(a));
    chk({tag, "_din"},  32'(ram_din),  32'(d));
  endtask

  initial begin
    int nwe;
    logic [22:0] e;
    for (int i = 0; i < 16384; i++) mem[i] = '0;

    // reset then idle
    tick(); tick();
    chk("rst_we",    32'(ram_we), 32'd0);
    chk("rst_addr",  32'(ram_addr), 32'd0);
    chk("rst_din",   32'(ram_din), 32'd0);
    chk("rst_ack",   32'(spi_ack), 32'd0);
    chk("rst_rdata", 32'(spi_rdata), 32'd0);
    chk("rst_full",  32'(z80_fifo_full), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    rst = 1'b0;
    nwe = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ram_we) nwe++;
    end
    chk("idle_we_cnt", 32'(nwe), 32'd0);

    // Z80 burst of three
    z80_wr_stb = 1'b1; z80_wr_addr = 14'h0400; z80_wr_data = 8'h11; tick();
    z80_wr_addr = 14'h0401; z80_wr_data = 8'h22; tick();
    chk_wr("burst0", 14'h0400, 8'h11);
    z80_wr_addr = 14'h0402; z80_wr_data = 8'h33; tick();
    chk_wr("burst1", 14'h0401, 8'h22);
    z80_wr_stb = 1'b0; tick();
    chk_wr("burst2", 14'h0402, 8'h33);
    tick();
    chk("burst_we_off", 32'(ram_we), 32'd0);
    chk("burst_ovf",    32'(overflow), 32'd0);
    chk("burst_busy",   32'(busy), 32'd0);

    // SPI write then read back
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 14'h1234; spi_wdata = 8'hA5; tick();
    chk_wr("spiw", 14'h1234, 8'hA5);
    chk("spiw_ack", 32'(spi_ack), 32'd1);
    tick();
    chk("spiw_ack_off", 32'(spi_ack), 32'd0);
    chk("spiw_we_off",  32'(ram_we), 32'd0);
    spi_we = 1'b0; tick();
    chk("spir_g1_ack",  32'(spi_ack), 32'd0);
    chk("spir_g1_we",   32'(ram_we), 32'd0);
    chk("spir_g1_addr", 32'(ram_addr), 32'h1234);
    chk("spir_g1_busy", 32'(busy), 32'd1);
    tick();
    chk("spir_g2_ack",  32'(spi_ack), 32'd0);
    tick();
    chk("spir_g3_ack",  32'(spi_ack), 32'd1);
    chk("spir_rdata",   32'(spi_rdata), 32'hA5);
    tick();
    spi_req = 1'b0;
    chk("spir_ack_off", 32'(spi_ack), 32'd0);
    chk("spir_hold",    32'(spi_rdata), 32'hA5);

    // FIFO overflow during an SPI read
    tick();
    spi_req = 1'b1; spi_we = 1'b0; spi_addr = 14'h1234;
    z80_wr_stb = 1'b1; z80_wr_addr = 14'h0500; z80_wr_data = 8'h55; tick();
    chk("ovf_rdaddr_we", 32'(ram_we), 32'd0);
    z80_wr_addr = 14'h0501; z80_wr_data = 8'h66; tick();
    z80_wr_addr = 14'h0502; z80_wr_data = 8'h77; tick();
    chk("ovf_ack",   32'(spi_ack), 32'd1);
    chk("ovf_rdata", 32'(spi_rdata), 32'hA5);
    chk("ovf_set",   32'(overflow), 32'd1);
    chk("ovf_full",  32'(z80_fifo_full), 32'd1);
    z80_wr_stb = 1'b0; tick();
    chk_wr("ovf_w0", 14'h0500, 8'h55);
    chk("ovf_ack_off", 32'(spi_ack), 32'd0);
    spi_req = 1'b0; tick();
    chk_wr("ovf_w1", 14'h0501, 8'h66);
    tick();
    chk("ovf_no_w2",  32'(ram_we), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_busy",   32'(busy), 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // push into a full FIFO in the same cycle as a pop
    spi_req = 1'b1; spi_we = 1'b0; spi_addr = 14'h1234;
    z80_wr_stb = 1'b1; z80_wr_addr = 14'h0700; z80_wr_data = 8'hA1; tick();
    z80_wr_addr = 14'h0701; z80_wr_data = 8'hA2; tick();
    chk("sim_full", 32'(z80_fifo_full), 32'd1);
    z80_wr_stb = 1'b0; tick();
    chk("sim_ack", 32'(spi_ack), 32'd1);
    z80_wr_stb = 1'b1; z80_wr_addr = 14'h0702; z80_wr_data = 8'hA3; tick();
    chk_wr("sim_w0", 14'h0700, 8'hA1);
    chk("sim_still_full", 32'(z80_fifo_full), 32'd1);
    chk("sim_ovf",        32'(overflow), 32'd0);
    z80_wr_stb = 1'b0; spi_req = 1'b0; tick();
    chk_wr("sim_w1", 14'h0701, 8'hA2);
    tick();
    chk_wr("sim_w2", 14'h0702, 8'hA3);
    tick();
    chk("sim_we_off", 32'(ram_we), 32'd0);
    chk("sim_busy",   32'(busy), 32'd0);

    // starvation: four Z80 grants, then the SPI write, then Z80 again
    log_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      z80_wr_stb = 1'b1; z80_wr_addr = 14'(16'h0600 + k); z80_wr_data = 8'(8'h80 + k);
      if (k == 1) begin
        spi_req = 1'b1; spi_we = 1'b1; spi_addr = 14'h2000; spi_wdata = 8'h5A;
      end
      if (k == 7) spi_req = 1'b0;
      tick();
    end
    z80_wr_stb = 1'b0;
    repeat (4) tick();
    log_en = 1'b0;
    chk("starve_nwr", 32'(wlog.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < 4)       e = {1'b0, 14'(16'h0600 + i), 8'(8'h80 + i)};
      else if (i == 4) e = {1'b1, 14'h2000, 8'h5A};
      else             e = {1'b0, 14'(16'h0600 + i - 1), 8'(8'h80 + i - 1)};
      if (i < wlog.size()) chk($sformatf("starve_wr%0d", i), 32'(wlog[i]), 32'(e));
      else chk($sformatf("starve_wr%0d", i), 32'hFFFF_FFFF, 32'(e));
    end
    if (wcyc.size() == 9) chk("starve_span", 32'(wcyc[8] - wcyc[0]), 32'd8);
    else chk("starve_span", 32'(wcyc.size()), 32'd9);
    chk("starve_ovf", 32'(overflow), 32'd0);
    chk("starve_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
